// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUop and func encodings shared by the ALU and the control unit
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SRA  = 6'b000011;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_XOR  = 6'b100110;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_SLTU = 6'b101011;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/control inputs and registered result of the ALU
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [5:0]       func;
  logic [1:0]       ALUop;
  logic [WIDTH-1:0] out;
  logic             zero;

  modport master (output A, B, func, ALUop, input out, zero);
  modport slave  (input A, B, func, ALUop, output out, zero);
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational decode and compute of the ALU result
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [5:0]       i_func,
  input  logic [1:0]       i_aluop,
  output logic [WIDTH-1:0] o_result
);
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_slt;
  logic [WIDTH-1:0] w_sltu;
  logic [WIDTH-1:0] w_result;

  // only the low bits of A select the shift distance; upper bits are ignored
  assign w_shamt = i_a[SHW-1:0];
  assign w_sum   = i_a + i_b;
  assign w_diff  = i_a - i_b;
  assign w_slt   = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
  assign w_sltu  = {{(WIDTH-1){1'b0}}, (i_a < i_b)};

  always_comb begin
    w_result = '0;
    case (i_aluop)
      ALUOP_ADD: w_result = w_sum;
      ALUOP_SUB: w_result = w_diff;
      ALUOP_OR:  w_result = i_a | i_b;
      default: begin
        case (i_func)
          FUNC_ADD, FUNC_ADDU: w_result = w_sum;
          FUNC_SUB, FUNC_SUBU: w_result = w_diff;
          FUNC_AND:  w_result = i_a & i_b;
          FUNC_OR:   w_result = i_a | i_b;
          FUNC_XOR:  w_result = i_a ^ i_b;
          FUNC_NOR:  w_result = ~(i_a | i_b);
          FUNC_SLT:  w_result = w_slt;
          FUNC_SLTU: w_result = w_sltu;
          FUNC_SLL:  w_result = i_b << w_shamt;
          FUNC_SRL:  w_result = i_b >> w_shamt;
          FUNC_SRA:  w_result = $signed(i_b) >>> w_shamt;
          default:   w_result = '0;
        endcase
      end
    endcase
  end

  assign o_result = w_result;

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - ALU top: combinational core followed by one output register stage
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_func   (bus.func),
    .i_aluop  (bus.ALUop),
    .o_result (w_result)
  );

  // zero is derived from the same result word so out and zero never disagree
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_zero <= 1'b1;
    end else begin
      r_out  <= w_result;
      r_zero <= (w_result == '0);
    end
  end

  assign bus.out  = r_out;
  assign bus.zero = r_zero;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for the ALU with directed hand-computed vectors
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst;
  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   checks;
  int   errors;
  bit   done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic r, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_out, input string name);
    exp_t e;
    @(negedge clk);
    rst       = r;
    bus.ALUop = op;
    bus.func  = fn;
    bus.A     = a;
    bus.B     = b;
    e.name = name;
    e.out  = exp_out;
    e.zero = (exp_out == 32'h0);
    q.push_back(e);
  endtask

  task automatic finish_run();
    if (!done) begin
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  // monitor: every output edge consumes the response expected for it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.out !== e.out) begin
          errors++;
          $display("FAIL %s out: got %h expected %h", e.name, bus.out, e.out);
        end
        checks++;
        if (bus.zero !== e.zero) begin
          errors++;
          $display("FAIL %s zero: got %b expected %b", e.name, bus.zero, e.zero);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_run();
  end

  initial begin
    checks = 0;
    errors = 0;
    done   = 1'b0;
    rst = 1'b1; bus.ALUop = 2'b00; bus.func = 6'h0; bus.A = 32'h0; bus.B = 32'h0;

    apply(1, ALUOP_ADD,   6'h00,     32'h1234_5678, 32'h1111_1111, 32'h0000_0000, "reset");
    apply(0, ALUOP_RTYPE, FUNC_ADD,  32'h1234_5678, 32'h0000_1111, 32'h1234_6789, "add");
    apply(0, ALUOP_SUB,   6'h00,     32'h0000_ABCD, 32'h0000_ABCD, 32'h0000_0000, "beq_sub");
    apply(0, ALUOP_ADD,   6'h00,     32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap");
    apply(0, ALUOP_RTYPE, FUNC_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_neg");
    apply(0, ALUOP_RTYPE, FUNC_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_big");
    apply(0, ALUOP_RTYPE, FUNC_SRA,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000, "sra4");
    apply(0, ALUOP_RTYPE, FUNC_SRL,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000, "srl4");
    apply(0, ALUOP_RTYPE, FUNC_SLL,  32'h0000_0024, 32'h0000_0001, 32'h0000_0010, "sll_amt_mask");
    apply(0, ALUOP_RTYPE, 6'b111111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, "bad_func");
    apply(0, ALUOP_OR,    6'h00,     32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, "ori");
    apply(0, ALUOP_RTYPE, FUNC_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "addu");
    apply(0, ALUOP_RTYPE, FUNC_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, "sub_neg");
    apply(0, ALUOP_RTYPE, FUNC_SUBU, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, "subu");
    apply(0, ALUOP_RTYPE, FUNC_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, "and");
    apply(0, ALUOP_RTYPE, FUNC_OR,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, "or");
    apply(0, ALUOP_RTYPE, FUNC_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, "xor");
    apply(0, ALUOP_RTYPE, FUNC_NOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h00F0_00F0, "nor");
    apply(0, ALUOP_RTYPE, FUNC_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, "slt_min");
    apply(0, ALUOP_RTYPE, FUNC_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, "sltu_min");
    apply(0, ALUOP_RTYPE, FUNC_SLT,  32'h0000_0003, 32'h0000_0003, 32'h0000_0000, "slt_equal");
    apply(0, ALUOP_RTYPE, FUNC_SRA,  32'hFFFF_FFE0, 32'h8000_0001, 32'h8000_0001, "sra_amt0");
    apply(0, ALUOP_RTYPE, FUNC_SRL,  32'h0000_001F, 32'h8000_0000, 32'h0000_0001, "srl31");
    apply(0, ALUOP_RTYPE, FUNC_SRA,  32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, "sra31");
    apply(0, ALUOP_ADD,   6'b111111, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, "add_ignores_func");
    apply(0, ALUOP_SUB,   FUNC_AND,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_ignores_func");
    apply(0, ALUOP_RTYPE, 6'b000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "undef_func");
    apply(0, ALUOP_ADD,   6'h00,     32'h0000_0001, 32'h0000_0002, 32'h0000_0003, "pre_rst_add");
    apply(1, ALUOP_ADD,   6'h00,     32'h0000_000A, 32'h0000_0014, 32'h0000_0000, "mid_rst");
    apply(0, ALUOP_ADD,   6'h00,     32'h0000_000A, 32'h0000_0014, 32'h0000_001E, "post_rst_add");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    finish_run();
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, data width of A, B and out; all requirements below assume WIDTH=32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 A  input  32  operand A; A[4:0] is the shift amount for shift operations.
REQ-005 B  input  32  operand B; the value that is shifted for shift operations.
REQ-006 func  input  6  R-type function field; used only when ALUop=2'b10.
REQ-007 ALUop  input  2  operation class from the main control unit.
REQ-008 out  output  32  registered result.
REQ-009 zero  output  1  registered flag, 1 when the registered out equals 0.

Function
REQ-010 The ALU SHALL decode ALUop as follows:
- 00: add (lw/sw address)
- 01: sub (beq/bne compare)
- 10: operation selected by func
- 11: bitwise OR (ori)
REQ-011 When ALUop=10, the ALU SHALL decode func as follows:
- 100000 add; 100001 addu; 100010 sub; 100011 subu
- 100100 and; 100101 or; 100110 xor; 100111 nor
- 101010 slt (signed); 101011 sltu (unsigned)
- 000000 sll: B<<A[4:0]; 000010 srl: B>>A[4:0] logical; 000011 sra: B>>>A[4:0] arithmetic
REQ-012 Any other func value with ALUop=10 SHALL produce result 0x00000000.
REQ-013 Add and sub SHALL be modulo 2^32, with overflow ignored and no trap; signed and unsigned variants SHALL give identical results.
REQ-014 slt/sltu SHALL produce 0x00000001 when A<B, else 0x00000000; slt compares two's complement, sltu compares unsigned.
REQ-015 The result SHALL be computed combinationally from the current inputs and registered into out on each rising clk edge: latency exactly 1 cycle, throughput 1 operation per cycle, no handshake.
REQ-016 zero SHALL be registered in the same edge as out and SHALL equal (result==0), so zero and out are always mutually consistent.
REQ-017 Shift amounts SHALL use only A[4:0]; A[31:5] SHALL be ignored.

Reset
REQ-018 When rst=1 at a rising edge, out SHALL become 0x00000000 and zero SHALL become 1, regardless of the other inputs.
REQ-019 Asserting rst mid-stream SHALL discard the in-flight result; the first valid output SHALL appear one cycle after rst deasserts.
REQ-020 Before the first reset edge, the output values are unspecified.

Structure
REQ-021 The ALUop encodings and func codes SHALL be localparams in a shared package (alu_pkg), which the control unit also uses.
REQ-022 The block SHALL be implemented as a combinational decode/compute section plus one output register stage; no sub-module is required (an optional alu_core for the combinational part is permitted).

Verification
REQ-023 ALUop=10, func=100000, A=0x12345678, B=0x00001111 -> next cycle out=0x12346789, zero=0.
REQ-024 ALUop=01, A=B=0x0000ABCD -> out=0, zero=1; ALUop=00, A=0xFFFFFFFF, B=1 -> out=0 (wrap-around), zero=1.
REQ-025 ALUop=10, slt, A=0xFFFFFFFF, B=1 -> out=1; same operands with sltu -> out=0.
REQ-026 ALUop=10, sra, A=4, B=0x80000000 -> out=0xF8000000; with srl -> out=0x08000000; with sll, A=0x24, B=1 -> out=0x10 (only A[4:0] used).
REQ-027 Apply a valid add, assert rst for one cycle -> out=0 and zero=1 on that edge; after rst deasserts, a new add appears after exactly 1 cycle.
REQ-028 ALUop=10, func=111111 -> out=0, zero=1; ALUop=11, A=0xF0F00000, B=0x0000F0F0 -> out=0xF0F0F0F0.
